// File: rtl/motor_speed_sequencer.sv
// Motor speed sequencer: mode FSM that drains to zero on every mode change and
// ramps the drive value one step per prescaler tick toward a per-mode target.
module motor_speed_sequencer #(
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned RUN_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] rank,
  input  logic [2:0] level,
  input  logic       control,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  output logic       data_ready,
  output logic [3:0] speed,
  output logic       send_en,
  output logic [2:0] mode,
  output logic       busy
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned RW = $clog2(RUN_TICKS + 1);

  typedef enum logic [2:0] {
    ST_STOP   = 3'b000,
    ST_MANUAL = 3'b001,
    ST_SEMI   = 3'b010,
    ST_AUTO   = 3'b011,
    ST_DRAIN  = 3'b100
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic [1:0]      rank_q, rank_d;
  logic            ctrl_meta_q, ctrl_meta_d;
  logic            ctrl_sync_q, ctrl_sync_d;
  logic            ctrl_prev_q, ctrl_prev_d;
  logic [RW-1:0]   run_cnt_q, run_cnt_d;
  logic [2:0]      auto_lvl_q, auto_lvl_d;
  logic [3:0]      speed_q, speed_d;

  logic            tick;
  logic            ctrl_rise;
  logic            accept;
  logic [3:0]      target;

  function automatic logic [3:0] level_to_speed(input logic [2:0] lvl);
    logic [3:0] s;
    case (lvl)
      3'd0:    s = 4'd0;
      3'd1:    s = 4'd1;
      3'd2:    s = 4'd5;
      3'd3:    s = 4'd7;
      3'd4:    s = 4'd9;
      3'd5:    s = 4'd13;
      default: s = 4'd15;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] byte_to_lvl(input logic [7:0] b);
    logic [2:0] l;
    if (b == 8'd0)        l = 3'd0;
    else if (b < 8'd30)   l = 3'd1;
    else if (b < 8'd60)   l = 3'd2;
    else if (b < 8'd90)   l = 3'd3;
    else if (b < 8'd120)  l = 3'd4;
    else if (b < 8'd150)  l = 3'd5;
    else                  l = 3'd6;
    return l;
  endfunction

  assign tick       = (pre_q == PW'(TICK_DIV - 1));
  assign ctrl_rise  = ctrl_sync_q & ~ctrl_prev_q;
  assign data_ready = (state_q == ST_AUTO);
  assign send_en    = (state_q == ST_AUTO);
  assign accept     = data_valid & data_ready;
  assign speed      = speed_q;
  assign mode       = state_q;
  assign busy       = (speed_q != target);

  // Target follows the registered state only, so a mode change affects the ramp a cycle later.
  always_comb begin
    target = 4'd0;
    case (state_q)
      ST_MANUAL: target = (run_cnt_q != '0) ? 4'd15 : 4'd0;
      ST_SEMI:   target = level_to_speed(level);
      ST_AUTO:   target = level_to_speed(auto_lvl_q);
      default:   target = 4'd0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    pre_d       = tick ? '0 : pre_q + PW'(1);
    rank_d      = rank;
    ctrl_meta_d = control;
    ctrl_sync_d = ctrl_meta_q;
    ctrl_prev_d = ctrl_sync_q;
    run_cnt_d   = run_cnt_q;
    auto_lvl_d  = auto_lvl_q;
    speed_d     = speed_q;

    // Any rank mismatch drains first; drain exits to whatever rank is current at zero speed.
    case (state_q)
      ST_DRAIN: if (speed_q == 4'd0) state_d = state_e'({1'b0, rank_q});
      default:  if (rank_q != state_q[1:0]) state_d = ST_DRAIN;
    endcase

    if (state_q != ST_MANUAL || state_d != ST_MANUAL) run_cnt_d = '0;
    else if (ctrl_rise)                                run_cnt_d = RW'(RUN_TICKS);
    else if (tick && run_cnt_q != '0)                  run_cnt_d = run_cnt_q - RW'(1);

    if (state_d == ST_AUTO && state_q != ST_AUTO) auto_lvl_d = 3'd0;
    else if (accept)                              auto_lvl_d = byte_to_lvl(data_in);

    if (tick) begin
      if (speed_q < target)      speed_d = speed_q + 4'd1;
      else if (speed_q > target) speed_d = speed_q - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_STOP;
      pre_q       <= '0;
      rank_q      <= 2'b00;
      ctrl_meta_q <= 1'b0;
      ctrl_sync_q <= 1'b0;
      ctrl_prev_q <= 1'b0;
      run_cnt_q   <= '0;
      auto_lvl_q  <= 3'd0;
      speed_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      pre_q       <= pre_d;
      rank_q      <= rank_d;
      ctrl_meta_q <= ctrl_meta_d;
      ctrl_sync_q <= ctrl_sync_d;
      ctrl_prev_q <= ctrl_prev_d;
      run_cnt_q   <= run_cnt_d;
      auto_lvl_q  <= auto_lvl_d;
      speed_q     <= speed_d;
    end
  end

endmodule

// File: tb/tb_motor_speed_sequencer.sv
// Scenario bench for motor_speed_sequencer: expected speed steps are queued as
// stimulus is applied and popped by a monitor whenever the drive value moves.
module tb_motor_speed_sequencer;

  localparam int unsigned TICK_DIV  = 4;
  localparam int unsigned RUN_TICKS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] rank;
  logic [2:0] level;
  logic       control;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic [3:0] speed;
  logic       send_en;
  logic [2:0] mode;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [3:0] exp_q[$];
  bit         mon_en = 1'b0;
  bit         mon_prev_valid = 1'b0;
  logic [3:0] last_speed = 4'd0;
  logic [3:0] mon_exp;
  int         last_chg = 0;

  motor_speed_sequencer #(.TICK_DIV(TICK_DIV), .RUN_TICKS(RUN_TICKS)) dut (
    .clk(clk), .rst(rst), .rank(rank), .level(level), .control(control),
    .data_in(data_in), .data_valid(data_valid), .data_ready(data_ready),
    .speed(speed), .send_en(send_en), .mode(mode), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each change of speed must match the next queued step, one tick apart.
  always @(negedge clk) begin
    if (mon_en && speed !== last_speed) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL speed_step: unexpected change %0d -> %0d at cycle %0d", last_speed, speed, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (speed !== mon_exp) begin
          errors++;
          $display("FAIL speed_step: got %0d expected %0d at cycle %0d", speed, mon_exp, cyc);
        end
      end
      if (mon_prev_valid) begin
        checks++;
        if (cyc - last_chg != int'(TICK_DIV)) begin
          errors++;
          $display("FAIL step_interval: got %0d cycles expected %0d", cyc - last_chg, TICK_DIV);
        end
      end
      mon_prev_valid = 1'b1;
      last_chg = cyc;
    end
    last_speed = speed;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push_ramp(input int from, input int to);
    int s;
    s = from;
    while (s != to) begin
      s += (to > s) ? 1 : -1;
      exp_q.push_back(4'(s));
    end
  endtask

  task automatic drain_sb(input int budget, output bit done);
    done = (exp_q.size() == 0);
    for (int i = 0; i < budget && !done; i++) begin
      step();
      done = (exp_q.size() == 0);
    end
  endtask

  task automatic wait_mode(input logic [2:0] m, input int budget, output bit hit);
    hit = (mode === m);
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      hit = (mode === m);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; rank = 2'b00; level = 3'd0; control = 1'b0;
    data_in = 8'd0; data_valid = 1'b0;
    step(); step();
    checks++; if (speed !== 4'd0)   begin errors++; $display("FAIL reset_speed: got %0d expected 0", speed); end
    checks++; if (mode !== 3'b000)  begin errors++; $display("FAIL reset_mode: got %b expected 000", mode); end
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL reset_send_en: got %b expected 0", send_en); end
    checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b1;
    step(); step();
    checks++; if (mode !== 3'b000)  begin errors++; $display("FAIL stop_hold: got %b expected 000", mode); end
  endtask

  task automatic test_semi_ramp();
    bit saw_drain, done;
    mon_prev_valid = 1'b0;
    mon_en = 1'b1;
    push_ramp(0, 15);
    rank = 2'b10; level = 3'd6;
    saw_drain = 1'b0;
    for (int i = 0; i < 20 && mode !== 3'b010; i++) begin
      step();
      if (mode === 3'b100) saw_drain = 1'b1;
    end
    checks++; if (mode !== 3'b010) begin errors++; $display("FAIL semi_entry: got %b expected 010", mode); end
    checks++; if (!saw_drain) begin errors++; $display("FAIL semi_via_drain: got 0 expected 1"); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL semi_busy_start: got %b expected 1", busy); end
    drain_sb(200, done);
    checks++; if (!done) begin errors++; $display("FAIL semi_ramp_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    step();
    checks++; if (speed !== 4'd15) begin errors++; $display("FAIL semi_top: got %0d expected 15", speed); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL semi_busy_end: got %b expected 0", busy); end
  endtask

  task automatic test_mode_change();
    bit done, hit;
    mon_en = 1'b0;
    rst = 1'b0; rank = 2'b00;
    step(); step();
    rst = 1'b1;
    step();
    exp_q.delete();
    mon_prev_valid = 1'b0;
    mon_en = 1'b1;
    push_ramp(0, 9);
    rank = 2'b10; level = 3'd6;
    drain_sb(200, done);
    checks++; if (!done) begin errors++; $display("FAIL mc_rampup_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    rank = 2'b11;
    push_ramp(9, 0);
    step(); step();
    checks++; if (mode !== 3'b100) begin errors++; $display("FAIL mc_drain: got %b expected 100", mode); end
    drain_sb(200, done);
    checks++; if (!done) begin errors++; $display("FAIL mc_drain_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    wait_mode(3'b011, 10, hit);
    checks++; if (!hit) begin errors++; $display("FAIL mc_auto_entry: got %b expected 011", mode); end
    checks++; if (send_en !== 1'b1) begin errors++; $display("FAIL mc_send_en: got %b expected 1", send_en); end
    checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL mc_data_ready: got %b expected 1", data_ready); end
    checks++; if (speed !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL mc_auto_idle: got speed %0d busy %b expected 0 0", speed, busy); end
  endtask

  task automatic test_auto_thresholds();
    logic [7:0] byte_tab [6];
    logic [3:0] tgt_tab  [6];
    int prev;
    bit done;
    byte_tab = '{8'd0, 8'd29, 8'd30, 8'd149, 8'd150, 8'd255};
    tgt_tab  = '{4'd0, 4'd1, 4'd5, 4'd13, 4'd15, 4'd15};
    prev = 0;
    for (int i = 0; i < 6; i++) begin
      mon_prev_valid = 1'b0;
      push_ramp(prev, int'(tgt_tab[i]));
      data_in = byte_tab[i]; data_valid = 1'b1;
      step();
      data_valid = 1'b0;
      checks++;
      if (busy !== (int'(tgt_tab[i]) != prev)) begin
        errors++; $display("FAIL auto_busy byte %0d: got %b expected %b", byte_tab[i], busy, int'(tgt_tab[i]) != prev);
      end
      drain_sb(100, done);
      checks++; if (!done) begin errors++; $display("FAIL auto_timeout byte %0d: got %0d left expected 0", byte_tab[i], exp_q.size()); exp_q.delete(); end
      step(); step();
      checks++;
      if (speed !== tgt_tab[i] || busy !== 1'b0) begin
        errors++; $display("FAIL auto_target byte %0d: got speed %0d busy %b expected %0d 0", byte_tab[i], speed, busy, tgt_tab[i]);
      end
      prev = int'(tgt_tab[i]);
    end
  endtask

  task automatic test_backpressure();
    bit hit, done;
    mon_prev_valid = 1'b0;
    push_ramp(15, 0);
    push_ramp(0, 5);
    rank = 2'b10; level = 3'd2;
    wait_mode(3'b010, 200, hit);
    checks++; if (!hit) begin errors++; $display("FAIL bp_semi_entry: got %b expected 010", mode); end
    data_in = 8'd0; data_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (data_ready !== 1'b0 || send_en !== 1'b0) begin
        errors++; $display("FAIL bp_ready: got ready %b send %b expected 0 0", data_ready, send_en);
      end
    end
    data_valid = 1'b0;
    checks++; if (dut.auto_lvl_q !== 3'd6) begin errors++; $display("FAIL bp_auto_lvl: got %0d expected 6", dut.auto_lvl_q); end
    drain_sb(200, done);
    checks++; if (!done) begin errors++; $display("FAIL bp_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    step();
    checks++; if (speed !== 4'd5 || busy !== 1'b0) begin errors++; $display("FAIL bp_semi_target: got speed %0d busy %b expected 5 0", speed, busy); end
  endtask

  task automatic test_manual();
    bit hit, done;
    mon_prev_valid = 1'b0;
    push_ramp(5, 0);
    rank = 2'b01;
    wait_mode(3'b001, 200, hit);
    checks++; if (!hit) begin errors++; $display("FAIL man_entry: got %b expected 001", mode); end
    drain_sb(20, done);
    checks++; if (!done || speed !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL man_idle: got speed %0d busy %b expected 0 0", speed, busy); exp_q.delete(); end
    // Single pulse: three ticks of target 15, then back to zero.
    mon_prev_valid = 1'b0;
    push_ramp(0, 3);
    push_ramp(3, 0);
    control = 1'b1;
    step(); step(); step();
    control = 1'b0;
    drain_sb(100, done);
    checks++; if (!done) begin errors++; $display("FAIL man_pulse_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    for (int i = 0; i < 8; i++) step();
    checks++; if (speed !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL man_pulse_end: got speed %0d busy %b expected 0 0", speed, busy); end
    // Retrigger two ticks into a run extends it by a full three ticks.
    mon_prev_valid = 1'b0;
    push_ramp(0, 2);
    control = 1'b1;
    step(); step(); step();
    control = 1'b0;
    drain_sb(100, done);
    checks++; if (!done) begin errors++; $display("FAIL man_pre_retrig_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    push_ramp(2, 5);
    push_ramp(5, 0);
    control = 1'b1;
    step(); step(); step();
    control = 1'b0;
    drain_sb(150, done);
    checks++; if (!done) begin errors++; $display("FAIL man_retrig_timeout: got %0d left expected 0", exp_q.size()); exp_q.delete(); end
    for (int i = 0; i < 8; i++) step();
    checks++; if (speed !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL man_retrig_end: got speed %0d busy %b expected 0 0", speed, busy); end
  endtask

  task automatic test_async_reset();
    bit hit, done;
    rank = 2'b11;
    wait_mode(3'b011, 50, hit);
    checks++; if (!hit) begin errors++; $display("FAIL ar_auto_entry: got %b expected 011", mode); end
    checks++; if (data_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL ar_auto_cleared: got ready %b busy %b expected 1 0", data_ready, busy); end
    mon_prev_valid = 1'b0;
    push_ramp(0, 7);
    data_in = 8'd60; data_valid = 1'b1;
    step();
    data_valid = 1'b0;
    drain_sb(100, done);
    checks++; if (!done || speed !== 4'd7) begin errors++; $display("FAIL ar_reach7: got speed %0d expected 7", speed); exp_q.delete(); end
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (speed !== 4'd0)   begin errors++; $display("FAIL ar_speed: got %0d expected 0", speed); end
    checks++; if (send_en !== 1'b0) begin errors++; $display("FAIL ar_send_en: got %b expected 0", send_en); end
    checks++; if (mode !== 3'b000)  begin errors++; $display("FAIL ar_mode: got %b expected 000", mode); end
    checks++; if (data_ready !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ar_ready_busy: got %b %b expected 0 0", data_ready, busy); end
    step(); step();
    checks++; if (mode !== 3'b000) begin errors++; $display("FAIL ar_held: got %b expected 000", mode); end
    rst = 1'b1;
    wait_mode(3'b011, 20, hit);
    checks++; if (!hit || send_en !== 1'b1) begin errors++; $display("FAIL ar_reentry: got mode %b send %b expected 011 1", mode, send_en); end
  endtask

  initial begin
    test_reset();
    test_semi_ramp();
    test_mode_change();
    test_auto_thresholds();
    test_backpressure();
    test_manual();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
